csr_bridge: RTL

Byte-stream-to-CSR bus master. Turns framed command/data bytes from a serial front end (I2C or SPI slave byte layer) into write and read cycles on the shared 5-bit-address, 8-bit-data CSR bus. It drives `csr_a`, `csr_di` and `csr_we`, and samples the registered `csr_do` returned by the CSR slaves. It is the single initiator of that bus.

---
 rtl/csr_bridge_pkg.sv | 29 ++
 rtl/csr_bridge_if.sv | 36 +++
 rtl/csr_bridge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/csr_bridge_pkg.sv
// csr_bridge_pkg: shared types and constants for the byte-stream-to-CSR bridge.
//   state_e     - bridge FSM states
//   CMD_*       - command byte field positions
//   CSR_ADDR_W  - CSR bus address width (fixed by the bus)
//   addr_inc    - wrapping address increment
package csr_bridge_pkg;

  localparam int unsigned CSR_ADDR_W  = 5;
  localparam int unsigned CMD_RD_BIT  = 7;
  localparam int unsigned CMD_RSVD_HI = 6;
  localparam int unsigned CMD_RSVD_LO = 5;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWdata,
    StWstb,
    StRaddr,
    StRcap,
    StRsend,
    StDrop
  } state_e;

  // Plain modular add: 31 wraps to 0 without any flag.
  function automatic logic [CSR_ADDR_W-1:0] addr_inc(input logic [CSR_ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/csr_bridge_if.sv
// csr_bridge_if: front-end byte stream, control pulses and CSR bus of the bridge.
//   start/stop            - framing pulses from the serial front end
//   rx_data/valid/ready   - inbound byte handshake
//   tx_data/valid/ready   - outbound (read) byte handshake
//   csr_a/di/we/do        - shared CSR bus (bridge is the only initiator)
//   busy/err              - status
// Modports: master = bridge side, slave = front end plus CSR slaves.
interface csr_bridge_if;
  import csr_bridge_pkg::*;

  logic                  start;
  logic                  stop;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [CSR_ADDR_W-1:0] csr_a;
  logic [7:0]            csr_di;
  logic                  csr_we;
  logic [7:0]            csr_do;
  logic                  busy;
  logic                  err;

  modport master (
    input  start, stop, rx_data, rx_valid, tx_ready, csr_do,
    output rx_ready, tx_data, tx_valid, csr_a, csr_di, csr_we, busy, err
  );

  modport slave (
    output start, stop, rx_data, rx_valid, tx_ready, csr_do,
    input  rx_ready, tx_data, tx_valid, csr_a, csr_di, csr_we, busy, err
  );

endinterface

// File: rtl/csr_bridge.sv
// csr_bridge: turns framed command/data bytes into CSR write and read cycles.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - csr_bridge_if.master (front-end byte streams, start/stop, CSR bus, status)
// Command byte: bit7 read/not-write, bits6:5 reserved (must be 0), bits4:0 address.
// Build option: define CSR_BRIDGE_AUTOINC_EN to advance the address after every
// write strobe and every delivered read byte; otherwise the command address is held.
// rx_ready and busy are decoded from the state; every other output is registered.
module csr_bridge
  import csr_bridge_pkg::*;
(
  input logic          clk,
  input logic          rst,
  csr_bridge_if.master bus
);

  localparam int unsigned ADDR_BITS = CSR_ADDR_W;

`ifdef CSR_BRIDGE_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] a_q, a_d;
  logic [7:0]           di_q, di_d;
  logic                 we_q, we_d;
  logic [7:0]           txd_q, txd_d;
  logic                 txv_q, txv_d;
  logic                 err_q, err_d;

  logic rx_ready;
  logic rx_hs;
  logic tx_hs;
  logic rd_state;

  assign rx_ready = (state_q != StWstb);
  assign rx_hs    = bus.rx_valid & rx_ready;
  assign tx_hs    = txv_q & bus.tx_ready;
  assign rd_state = (state_q == StRaddr) || (state_q == StRcap) || (state_q == StRsend);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      di_q    <= '0;
      we_q    <= 1'b0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      di_q    <= di_d;
      we_q    <= we_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    di_d    = di_q;
    we_d    = 1'b0;
    txd_d   = txd_q;
    txv_d   = txv_q;
    err_d   = err_q;

    // A strobe already on the bus completes, including its address step,
    // even when start or stop lands in the same cycle.
    if (state_q == StWstb && AutoInc) begin
      a_d = addr_inc(a_q);
    end

    if (bus.start) begin
      // Beats stop; a strobe pending from a WDATA handshake is dropped via we_d default.
      state_d = StCmd;
      txv_d   = 1'b0;
      err_d   = 1'b0;
    end else if (bus.stop) begin
      state_d = StIdle;
      txv_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StDrop: ;
        StCmd: begin
          if (rx_hs) begin
            if (|bus.rx_data[CMD_RSVD_HI:CMD_RSVD_LO]) begin
              state_d = StDrop;
              err_d   = 1'b1;
            end else begin
              a_d     = bus.rx_data[ADDR_BITS-1:0];
              state_d = bus.rx_data[CMD_RD_BIT] ? StRaddr : StWdata;
            end
          end
        end
        StWdata: begin
          if (rx_hs) begin
            di_d    = bus.rx_data;
            we_d    = 1'b1;
            state_d = StWstb;
          end
        end
        StWstb:  state_d = StWdata;
        StRaddr: state_d = StRcap;
        StRcap: begin
          txd_d   = bus.csr_do;
          txv_d   = 1'b1;
          state_d = StRsend;
        end
        StRsend: begin
          if (tx_hs) begin
            txv_d   = 1'b0;
            state_d = StRaddr;
            if (AutoInc) begin
              a_d = addr_inc(a_q);
            end
          end
        end
      endcase

      // Inbound bytes have no meaning during a read.
      if (rd_state && rx_hs) begin
        err_d = 1'b1;
      end
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.busy     = (state_q != StIdle);
  assign bus.csr_a    = a_q;
  assign bus.csr_di   = di_q;
  assign bus.csr_we   = we_q;
  assign bus.tx_data  = txd_q;
  assign bus.tx_valid = txv_q;
  assign bus.err      = err_q;

endmodule
